// File: rtl/adain_sched_pkg.sv
// Shared types and constants for the AdaIN channel scheduler: FSM state
// encoding, core handshake codes and width helpers.
package adain_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ST_START,
        ST_STREAM,
        ST_WAIT,
        NM_START,
        NM_STREAM,
        NM_WAIT,
        NEXT_CH
    } sched_state_t;

    localparam logic [1:0] CORE_START_IDLE = 2'b00;
    localparam logic [1:0] CORE_START_STAT = 2'b01;
    localparam logic [1:0] CORE_START_NORM = 2'b10;

    localparam logic [1:0] CORE_DONE_STAT = 2'b01;
    localparam logic [1:0] CORE_DONE_OUT  = 2'b10;

    localparam int N_MAX_DEF       = 128;
    localparam int C_MAX_DEF       = 512;
    localparam int RD_LAT_DEF      = 1;
    localparam int WDOG_CYCLES_DEF = 4096;

    // Bit width needed to hold values 0..max_val-1, never less than one bit.
    function automatic int width_of(input int max_val);
        return (max_val <= 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/adain_stream_cnt.sv
// N-cycle read strobe / index generator; one pulse on start produces n
// back-to-back strobes with indices 0..n-1, flagging the final one.
module adain_stream_cnt #(
    parameter int NW = 8,
    parameter int IW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] n,
    output logic          run,
    output logic [IW-1:0] idx,
    output logic          last
);

    logic [IW-1:0] idx_q;

    assign last = run && (NW'(idx_q) == n - NW'(1));
    assign idx  = run ? idx_q : '0;

    // The index stops at n-1 and the strobe drops instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run   <= 1'b0;
            idx_q <= '0;
        end else if (start) begin
            run   <= 1'b1;
            idx_q <= '0;
        end else if (run) begin
            if (last) begin
                run <= 1'b0;
            end else begin
                idx_q <= idx_q + IW'(1);
            end
        end
    end

endmodule

// File: rtl/adain_channel_sched.sv
// Channel-level sequencer for the AdaIN core (stats pass, then normalise pass,
// per channel). Optional stall watchdog enabled by `define ADAIN_SCHED_WDOG_EN.
module adain_channel_sched
    import adain_sched_pkg::*;
#(
    parameter int N_MAX       = N_MAX_DEF,
    parameter int C_MAX       = C_MAX_DEF,
    parameter int RD_LAT      = RD_LAT_DEF,
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEF,
    localparam int NW = width_of(N_MAX + 1),
    localparam int IW = width_of(N_MAX),
    localparam int CW = width_of(C_MAX + 1),
    localparam int HW = width_of(C_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_start,
    input  logic [NW-1:0] cfg_n,
    input  logic [CW-1:0] cfg_c,
    output logic          busy,
    output logic          layer_done,
    output logic          cfg_err,
    output logic          fm_rd_en,
    output logic [HW-1:0] fm_rd_ch,
    output logic [IW-1:0] fm_rd_idx,
    output logic          style_rd_en,
    output logic [HW-1:0] style_rd_ch,
    output logic [1:0]    core_start,
    output logic [NW-1:0] core_N,
    input  logic [1:0]    core_done,
    output logic          out_valid,
    output logic [HW-1:0] out_ch,
    output logic [IW-1:0] out_idx
);

    localparam logic [NW-1:0] N_LIM = NW'(N_MAX);

    // Read latency is absorbed on the buffer side; only its range is checked.
    if (RD_LAT < 1 || RD_LAT > 4 || WDOG_CYCLES < 2) begin : g_bad_param
        $error("adain_channel_sched: RD_LAT must be 1..4 and WDOG_CYCLES at least 2");
    end

    sched_state_t  state, state_next;
    logic [NW-1:0] n_q;
    logic [CW-1:0] c_q;
    logic [HW-1:0] ch_q;
    logic [NW-1:0] out_cnt;
    logic          done_q, err_q;
    logic          stream_start, stream_run, stream_last;
    logic [IW-1:0] stream_idx;
    logic          cfg_n_ok, accept, in_norm, out_fire, outs_done, last_ch;
    logic          wd_abort;

    assign cfg_n_ok  = (cfg_n != '0) && (cfg_n <= N_LIM);
    assign accept    = (state == IDLE) && cfg_start && cfg_n_ok && (cfg_c != '0);
    assign in_norm   = (state == NM_STREAM) || (state == NM_WAIT);
    assign out_fire  = in_norm && (core_done == CORE_DONE_OUT) && (out_cnt != n_q);
    assign outs_done = (out_fire && (out_cnt == n_q - NW'(1))) || (out_cnt == n_q);
    assign last_ch   = (CW'(ch_q) + CW'(1)) == c_q;

    adain_stream_cnt #(
        .NW(NW),
        .IW(IW)
    ) u_stream (
        .clk  (clk),
        .rst  (rst),
        .start(stream_start),
        .n    (n_q),
        .run  (stream_run),
        .idx  (stream_idx),
        .last (stream_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        stream_start = 1'b0;
        core_start   = CORE_START_IDLE;
        style_rd_en  = 1'b0;
        case (state)
            IDLE:      if (accept) state_next = ST_START;
            ST_START: begin
                core_start   = CORE_START_STAT;
                style_rd_en  = 1'b1;
                stream_start = 1'b1;
                state_next   = ST_STREAM;
            end
            ST_STREAM: if (stream_last) state_next = ST_WAIT;
            ST_WAIT:   if (core_done == CORE_DONE_STAT) state_next = NM_START;
            NM_START: begin
                core_start   = CORE_START_NORM;
                stream_start = 1'b1;
                state_next   = NM_STREAM;
            end
            NM_STREAM: if (stream_last) state_next = outs_done ? NEXT_CH : NM_WAIT;
            NM_WAIT:   if (outs_done) state_next = NEXT_CH;
            NEXT_CH:   state_next = last_ch ? IDLE : ST_START;
            default:   state_next = IDLE;
        endcase
        if (wd_abort) begin
            state_next = IDLE;
        end
    end

    // Layer configuration, channel walk, output tagging and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q     <= '0;
            c_q     <= '0;
            ch_q    <= '0;
            out_cnt <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if ((state == IDLE) && cfg_start) begin
                if (!cfg_n_ok) begin
                    err_q <= 1'b1;
                end else if (cfg_c == '0) begin
                    done_q <= 1'b1;
                end
            end
            if (accept) begin
                n_q  <= cfg_n;
                c_q  <= cfg_c;
                ch_q <= '0;
            end
            if (state == NEXT_CH) begin
                if (last_ch) begin
                    done_q <= 1'b1;
                end else begin
                    ch_q <= ch_q + HW'(1);
                end
            end
            if (state == NM_START) begin
                out_cnt <= '0;
            end else if (out_fire) begin
                out_cnt <= out_cnt + NW'(1);
            end
            if (wd_abort) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef ADAIN_SCHED_WDOG_EN
    localparam int WW = width_of(WDOG_CYCLES + 1);

    logic [WW-1:0] wd_cnt;
    logic          in_wait, wd_evt;

    assign in_wait  = (state == ST_WAIT) || (state == NM_WAIT);
    assign wd_evt   = ((state == ST_WAIT) && (core_done == CORE_DONE_STAT)) || out_fire;
    assign wd_abort = in_wait && !wd_evt && (wd_cnt == WW'(WDOG_CYCLES - 1));

    // Counts consecutive idle wait cycles; any state change or accepted event restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (in_wait && (state_next == state) && !wd_evt) begin
            wd_cnt <= wd_cnt + WW'(1);
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign wd_abort = 1'b0;
`endif

    assign busy        = (state != IDLE);
    assign layer_done  = done_q;
    assign cfg_err     = err_q;
    assign core_N      = busy ? n_q : '0;
    assign style_rd_ch = style_rd_en ? ch_q : '0;
    assign fm_rd_en    = stream_run;
    assign fm_rd_ch    = stream_run ? ch_q : '0;
    assign fm_rd_idx   = stream_idx;
    assign out_valid   = out_fire;
    assign out_ch      = out_fire ? ch_q : '0;
    assign out_idx     = out_fire ? out_cnt[IW-1:0] : '0;

endmodule

// File: tb/tb_adain_channel_sched.sv
// Self-checking bench for adain_channel_sched: reactive core model plus an
// event-timeline reference; ADAIN_SCHED_WDOG_EN adds the stall-abort scenario.
module tb_adain_channel_sched;

    localparam int N_MAX  = 128;
    localparam int C_MAX  = 512;
    localparam int RD_LAT = 1;
`ifdef ADAIN_SCHED_WDOG_EN
    localparam int WDOG = 16;
`else
    localparam int WDOG = 4096;
`endif

    logic       clk, rst, cfg_start;
    logic [7:0] cfg_n;
    logic [9:0] cfg_c;
    logic       busy, layer_done, cfg_err, fm_rd_en, style_rd_en, out_valid;
    logic [8:0] fm_rd_ch, style_rd_ch, out_ch;
    logic [6:0] fm_rd_idx, out_idx;
    logic [1:0] core_start, core_done;
    logic [7:0] core_N;

    adain_channel_sched #(
        .N_MAX(N_MAX), .C_MAX(C_MAX), .RD_LAT(RD_LAT), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_n(cfg_n), .cfg_c(cfg_c),
        .busy(busy), .layer_done(layer_done), .cfg_err(cfg_err),
        .fm_rd_en(fm_rd_en), .fm_rd_ch(fm_rd_ch), .fm_rd_idx(fm_rd_idx),
        .style_rd_en(style_rd_en), .style_rd_ch(style_rd_ch),
        .core_start(core_start), .core_N(core_N), .core_done(core_done),
        .out_valid(out_valid), .out_ch(out_ch), .out_idx(out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference timeline: cycle numbers at which each observable event is due.
    bit   busy_e = 0;
    int   n_e = 0, c_e = 0, ch_e = 0, phase = 0;
    int   start_at = -1, rd_from = -1, rd_left = 0;
    logic [1:0] start_code = 2'b00;
    int   stat_due = -1, outs_got = 0, last_due = 0;
    int   ld_at = -1, err_at = -1, end_at = -1;
    int   q_due[$];
    bit   noise_en = 0, mute = 0;

    int   n_fm = 0, n_style = 0, n_out = 0, n_ld = 0, n_err = 0, n_busy = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic clearCounts();
        n_fm = 0; n_style = 0; n_out = 0; n_ld = 0; n_err = 0; n_busy = 0;
    endtask

    task automatic applyStimulus(input int n, input int c);
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_n = 8'(n);
        cfg_c = 10'(c);
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int k = 0;
        @(negedge clk);
        while ((busy_e || ld_at >= cyc || err_at >= cyc) && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (k >= budget) begin
            failures++;
            $display("[TB] FAIL %s_timeout: waited %0d cycles, limit %0d", name, k, budget);
        end
    endtask

    // Core model and per-cycle compare: drive core_done at negedge, sample 1ns later.
    always begin
        bit         genuine;
        logic [1:0] cd;
        int         r, due;
        @(negedge clk);
        cyc++;
        if (rst) begin
            busy_e = 0; phase = 0; start_at = -1; rd_left = 0; stat_due = -1;
            ld_at = -1; err_at = -1; end_at = -1; q_due.delete();
        end
        genuine = 0;
        cd = 2'b00;
        if (stat_due == cyc) begin
            cd = 2'b01;
        end else if (q_due.size() > 0 && q_due[0] == cyc) begin
            void'(q_due.pop_front());
            cd = 2'b10;
            genuine = 1;
        end else if (noise_en) begin
            r = $urandom_range(0, 7);
            if (phase == 1 && r < 2) cd = 2'b10;
            else if (r == 2) cd = 2'b11;
        end
        core_done = cd;
        #1;
        if (rst) begin
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_core_start", core_start, 0);
            checkOutput("rst_fm_rd_en", fm_rd_en, 0);
            checkOutput("rst_style_rd_en", style_rd_en, 0);
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_layer_done", layer_done, 0);
            checkOutput("rst_cfg_err", cfg_err, 0);
            checkOutput("rst_core_N", core_N, 0);
        end else begin
            logic [1:0] e_cs;
            bit         e_rd;
            if (cyc == end_at) busy_e = 0;
            e_cs = (cyc == start_at) ? start_code : 2'b00;
            e_rd = (rd_left > 0) && (cyc >= rd_from);
            checkOutput("core_start", core_start, e_cs);
            checkOutput("style_rd_en", style_rd_en, e_cs == 2'b01);
            if (e_cs == 2'b01) checkOutput("style_rd_ch", style_rd_ch, ch_e);
            checkOutput("fm_rd_en", fm_rd_en, e_rd);
            if (e_rd) begin
                checkOutput("fm_rd_ch", fm_rd_ch, ch_e);
                checkOutput("fm_rd_idx", fm_rd_idx, n_e - rd_left);
            end
            checkOutput("out_valid", out_valid, genuine);
            if (genuine) begin
                checkOutput("out_ch", out_ch, ch_e);
                checkOutput("out_idx", out_idx, outs_got);
            end
            checkOutput("busy", busy, busy_e);
            checkOutput("core_N", core_N, busy_e ? n_e : 0);
            checkOutput("layer_done", layer_done, cyc == ld_at);
            checkOutput("cfg_err", cfg_err, cyc == err_at);

            if (fm_rd_en) n_fm++;
            if (style_rd_en) n_style++;
            if (out_valid) n_out++;
            if (layer_done) n_ld++;
            if (cfg_err) n_err++;
            if (busy) n_busy++;

            if (e_rd) begin
                rd_left--;
                if (phase == 1 && rd_left == 0) begin
                    if (mute) begin
                        err_at = cyc + 1 + WDOG;
                        end_at = cyc + 1 + WDOG;
                        phase = 0;
                    end else begin
                        stat_due = cyc + $urandom_range(1, 5);
                    end
                end else if (phase == 2) begin
                    due = cyc + RD_LAT + $urandom_range(0, 2);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    q_due.push_back(due);
                end
            end
            if (cd == 2'b01) begin
                stat_due = -1;
                start_at = cyc + 1; start_code = 2'b10;
                rd_from = cyc + 2; rd_left = n_e;
                phase = 2; outs_got = 0; last_due = 0;
            end
            if (genuine) begin
                outs_got++;
                if (outs_got == n_e) begin
                    if (ch_e == c_e - 1) begin
                        ld_at = cyc + 2; end_at = cyc + 2; phase = 0;
                    end else begin
                        ch_e++;
                        start_at = cyc + 2; start_code = 2'b01;
                        rd_from = cyc + 3; rd_left = n_e; phase = 1;
                    end
                end
            end
            if (cfg_start && !busy_e) begin
                if (cfg_n == 0 || cfg_n > N_MAX) begin
                    err_at = cyc + 1;
                end else if (cfg_c == 0) begin
                    ld_at = cyc + 1;
                end else begin
                    busy_e = 1; n_e = cfg_n; c_e = cfg_c; ch_e = 0;
                    start_at = cyc + 1; start_code = 2'b01;
                    rd_from = cyc + 2; rd_left = n_e; phase = 1;
                end
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1; cfg_start = 1'b0; cfg_n = '0; cfg_c = '0; core_done = 2'b00;
        repeat (3) @(negedge clk);
        #2;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_core_start", core_start, 0);
        checkOutput("reset_core_N", core_N, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] basic layer n=4 c=2");
        clearCounts();
        applyStimulus(4, 2);
        waitIdle("basic", 400);
        checkOutput("basic_fm_reads", n_fm, 16);
        checkOutput("basic_style_reads", n_style, 2);
        checkOutput("basic_outputs", n_out, 8);
        checkOutput("basic_layer_done", n_ld, 1);
        checkOutput("basic_busy_after", busy, 0);

        $display("[TB] config rejection and empty layer");
        clearCounts();
        applyStimulus(0, 2);
        waitIdle("n_zero", 20);
        checkOutput("n_zero_err", n_err, 1);
        applyStimulus(129, 2);
        waitIdle("n_big", 20);
        checkOutput("n_big_err", n_err, 2);
        applyStimulus(8, 0);
        waitIdle("c_zero", 20);
        checkOutput("c_zero_done", n_ld, 1);
        checkOutput("reject_fm_reads", n_fm, 0);
        checkOutput("reject_busy_cycles", n_busy, 0);

        $display("[TB] start ignored while busy, spurious core_done codes");
        noise_en = 1;
        clearCounts();
        applyStimulus(6, 2);
        k = 0;
        while (!(phase == 1 && ch_e == 0 && rd_left > 0 && rd_left < 6) && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput("busy_start_reached", k < 100, 1);
        cfg_start = 1'b1; cfg_n = 8'd5; cfg_c = 10'd1;
        @(negedge clk);
        cfg_start = 1'b0;
        waitIdle("busy_start", 600);
        checkOutput("busy_start_fm_reads", n_fm, 24);
        checkOutput("busy_start_style_reads", n_style, 2);
        checkOutput("busy_start_outputs", n_out, 12);
        checkOutput("busy_start_layer_done", n_ld, 1);
        checkOutput("busy_start_err", n_err, 0);

        $display("[TB] randomized layers");
        for (int t = 0; t < 5; t++) begin
            int rn, rc;
            rn = $urandom_range(1, 20);
            rc = $urandom_range(1, 3);
            clearCounts();
            applyStimulus(rn, rc);
            waitIdle("rand", 2000);
            checkOutput("rand_fm_reads", n_fm, 2 * rn * rc);
            checkOutput("rand_outputs", n_out, rn * rc);
            checkOutput("rand_layer_done", n_ld, 1);
        end
        applyStimulus(N_MAX, 1);
        waitIdle("nmax", 2000);

        $display("[TB] reset during normalise stream of channel 1");
        clearCounts();
        applyStimulus(5, 3);
        k = 0;
        while (!(phase == 2 && ch_e == 1 && rd_left > 0 && rd_left < 5) && k < 300) begin
            @(negedge clk);
            k++;
        end
        checkOutput("midrst_reached", k < 300, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_fm_rd_en", fm_rd_en, 0);
        checkOutput("midrst_core_start", core_start, 0);
        checkOutput("midrst_core_N", core_N, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clearCounts();
        repeat (20) @(negedge clk);
        checkOutput("midrst_no_done", n_ld, 0);
        checkOutput("midrst_no_reads", n_fm, 0);
        applyStimulus(3, 2);
        waitIdle("after_rst", 400);
        checkOutput("after_rst_fm_reads", n_fm, 12);
        checkOutput("after_rst_layer_done", n_ld, 1);

`ifdef ADAIN_SCHED_WDOG_EN
        $display("[TB] watchdog on missing stats-done");
        clearCounts();
        mute = 1;
        applyStimulus(4, 1);
        waitIdle("wdog", 200);
        mute = 0;
        checkOutput("wdog_err", n_err, 1);
        checkOutput("wdog_no_done", n_ld, 0);
        checkOutput("wdog_busy", busy, 0);
        checkOutput("wdog_fm_reads", n_fm, 4);
`endif

        noise_en = 0;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        failures++;
        $display("[TB] FAIL global_timeout: simulation time %0t exceeded limit", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] global timeout");
    end

endmodule

// File: doc/adain_channel_sched.md
Name: adain_channel_sched

Overview:
- Channel-level sequencer for the AdaIN core.
- For each of C channels it drives the two-pass protocol: pass 1 (statistics, start=2'b01) streams N samples; pass 2 (normalise, start=2'b10) re-streams the same N samples.
- Generates feature-buffer and style-coefficient read addresses, tags core outputs with channel/sample index, and reports completion of the whole layer.

Parameters:
- N_MAX, 128, max samples per channel.
- C_MAX, 512, max channels per layer.
- RD_LAT, 1, feature/style buffer read latency in cycles (1..4).
- WDOG_CYCLES, 4096, watchdog limit (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_start  in  1  one-cycle layer start request
- cfg_n  in  $clog2(N_MAX+1)  samples per channel, sampled on accepted cfg_start
- cfg_c  in  $clog2(C_MAX+1)  channel count, sampled on accepted cfg_start
- busy  out  1  high from accepted start to layer_done
- layer_done  out  1  one-cycle pulse, layer finished
- cfg_err  out  1  one-cycle pulse, start rejected (or watchdog abort)
- fm_rd_en  out  1  feature buffer read strobe
- fm_rd_ch  out  $clog2(C_MAX)  feature read channel
- fm_rd_idx  out  $clog2(N_MAX)  feature read sample index
- style_rd_en  out  1  style ys/yb read strobe
- style_rd_ch  out  $clog2(C_MAX)  style read channel
- core_start  out  2  core start code (01 stats, 10 normalise, 00 idle)
- core_N  out  $clog2(N_MAX+1)  held N for core
- core_done  in  2  core status (01 stats-done pulse, 10 valid output)
- out_valid  out  1  core out is a valid normalised sample
- out_ch  out  $clog2(C_MAX)  channel tag for out
- out_idx  out  $clog2(N_MAX)  sample tag for out

Behaviour:
- Reset: all outputs 0, core_start=2'b00, FSM in IDLE, counters 0.
- FSM states: IDLE, ST_START, ST_STREAM, ST_WAIT, NM_START, NM_STREAM, NM_WAIT, NEXT_CH.
- IDLE:
  - cfg_start with 1<=cfg_n<=N_MAX and cfg_c>=1: latch N and C, ch=0, busy=1, go to ST_START.
  - cfg_n=0 or cfg_n>N_MAX: cfg_err pulse, stay IDLE.
  - cfg_c=0 (with valid cfg_n): layer_done pulse next cycle, busy never rises.
- cfg_start while busy: ignored, no error.
- ST_START:
  - core_start=01 for exactly 1 cycle; style_rd_en=1 with style_rd_ch=ch in the same cycle.
  - External logic holds ys/yb stable until the channel ends.
- ST_STREAM:
  - fm_rd_en=1 for exactly N consecutive cycles, fm_rd_idx 0..N-1, fm_rd_ch=ch.
  - First read occurs in the cycle after the core_start pulse.
  - Data reaches core input RD_LAT cycles after each strobe (buffer-side timing; the scheduler adds no gaps).
- ST_WAIT: hold until core_done==2'b01. Any other core_done value is ignored.
- NM_START: core_start=10 for 1 cycle.
- NM_STREAM: identical read sequence to ST_STREAM.
- NM_WAIT / output tagging:
  - Every cycle with core_done==2'b10 asserts out_valid combinationally with out_ch=ch and out_idx=output count, then increments the count.
  - Outputs may begin while NM_STREAM is still active; counting runs in both states.
  - After the N-th output, go to NEXT_CH.
- NEXT_CH:
  - ch==C-1: layer_done pulse, busy=0, go to IDLE.
  - Otherwise ch+1 and go to ST_START.
  - Each channel transition adds exactly one bubble cycle.
- core_done==2'b11 is illegal: ignored.
- core_done==2'b10 outside NM_STREAM/NM_WAIT: ignored, out_valid=0.
- core_N holds the latched N throughout busy; it is 0 in IDLE.
- Counters do not wrap: sample counters saturate at N-1 and terminate; the channel counter terminates at C-1.
- Reset mid-operation: immediate abort, all outputs to reset values, no layer_done.

Optional Feature:
- Macro ADAIN_SCHED_WDOG_EN.
- Defined:
  - A cycle counter runs in ST_WAIT and NM_WAIT and clears on each state entry and on every accepted core_done event.
  - Reaching WDOG_CYCLES aborts: cfg_err pulse, core_start=00, busy=0, return to IDLE, no layer_done.
- Undefined: the wait states hang indefinitely; the counter and the WDOG_CYCLES comparison are absent. cfg_err is driven only by config rejection.

Decomposition:
- Package adain_sched_pkg holds:
  - State enum.
  - Core start codes CORE_START_IDLE=2'b00, CORE_START_STAT=2'b01, CORE_START_NORM=2'b10.
  - Done codes CORE_DONE_STAT=2'b01, CORE_DONE_OUT=2'b10.
  - Width helper constants.
- One sub-module, adain_stream_cnt: a reusable N-cycle read strobe/index generator with start, run, last outputs. It is instantiated once and shared by both stream phases.

Test Plan:
- Config cfg_n=4, cfg_c=2; model core returns stats-done 3 cycles after the last read and 4 outputs back-to-back → 16 fm reads, 2 style reads, 8 out_valid tagged (0,0..3),(1,0..3), one layer_done, busy low afterwards.
- cfg_n=0, then cfg_n=129 → cfg_err pulse each time, busy stays 0, no reads. Then cfg_c=0 with cfg_n=8 → layer_done one cycle after start, no reads.
- cfg_start pulsed during ST_STREAM of channel 0 → ignored; sequence identical to an undisturbed run.
- Spurious core_done=2'b10 during ST_WAIT and core_done=2'b11 during NM_WAIT → no out_valid, counts unaffected.
- rst asserted mid NM_STREAM of channel 1 (cfg_c=3) → outputs zero asynchronously, no layer_done; a fresh start afterwards completes normally.
- With ADAIN_SCHED_WDOG_EN and WDOG_CYCLES=16, core never answers stats → cfg_err after 16 wait cycles, busy=0, FSM in IDLE.
